// File: rtl/bloom_probe_engine.sv
// Sequential Bloom-filter probe engine: double-hashes a key into K indices and
// reads (and for inserts, sets) one filter bit per cycle, then presents the K probe bits.
module bloom_probe_engine #(
  parameter int LOG_M = 8,
  parameter int W     = 32,
  parameter int K     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_key,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_probe,
  output logic             out_op,
  output logic [CNT_W-1:0] insert_count
);

  localparam int M   = 1 << LOG_M;
  localparam int PCW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [M-1:0]     filt;
  logic [LOG_M-1:0] idx;
  logic [LOG_M-1:0] h2;
  logic [PCW-1:0]   pcnt;
  logic             op_q;
  logic [K-1:0]     probe_q;

  logic [LOG_M-1:0] h1_in;
  logic [LOG_M-1:0] h2_in;
  logic             accept;
  logic             last;

  assign h1_in = in_key[LOG_M-1:0] ^ in_key[2*LOG_M-1:LOG_M];
  // Odd stride guarantees K distinct indices modulo a power-of-two M.
  assign h2_in = (in_key[3*LOG_M-1:2*LOG_M] ^ in_key[4*LOG_M-1:3*LOG_M]) | LOG_M'(1);

  assign in_ready  = (state == S_IDLE) && !clr;
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (pcnt == PCW'(K - 1));
  assign out_probe = probe_q;
  assign out_op    = op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_PROBE;
      S_PROBE: if (last) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt         <= '0;
      idx          <= '0;
      h2           <= '0;
      pcnt         <= '0;
      op_q         <= 1'b0;
      probe_q      <= '0;
      insert_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr) begin
            filt         <= '0;
            insert_count <= '0;
          end else if (in_valid) begin
            idx     <= h1_in;
            h2      <= h2_in;
            op_q    <= in_op;
            pcnt    <= '0;
            probe_q <= '0;
          end
        end
        S_PROBE: begin
          // Sampled before this cycle's own write lands, so inserts report prior presence.
          probe_q[pcnt] <= filt[idx];
          if (op_q) filt[idx] <= 1'b1;
          idx  <= idx + h2;
          pcnt <= pcnt + PCW'(1);
          if (last && op_q && (insert_count != '1))
            insert_count <= insert_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bloom_probe_engine.md
# bloom_probe_engine

Sequential Bloom-filter probe engine. It accepts one key per transaction and derives K bit-array indices by double hashing. It reads (and, for inserts, sets) one bit of an on-chip M-bit filter array per cycle. It then emits the K collected probe bits as a vector. The downstream AND-condense stage reduces that vector to a single "possibly present" flag, so this block sits directly upstream of it.

## Interface
Parameters:
- `LOG_M`, 8, log2 of filter size; M = 2^LOG_M bits.
- `W`, 32, key width; fixed at W = 4*LOG_M.
- `K`, 4, number of hash probes per key; 1..16.
- `CNT_W`, 16, width of the insert counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clr`  in  1  clears the filter array and the insert counter; honoured only in IDLE.
- `in_valid`  in  1  key/op valid.
- `in_ready`  out  1  engine can accept a key.
- `in_key`  in  W  key.
- `in_op`  in  1  0 = query, 1 = insert.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_probe`  out  K  probe bits; bit i is the array bit at probe index i.
- `out_op`  out  1  op of the transaction that produced the result.
- `insert_count`  out  CNT_W  number of completed inserts; saturates at all-ones.

## Operation
- Hash (key split into four LOG_M-bit slices s0 (LSB) .. s3):
  - h1 = s0 ^ s1
  - h2 = (s2 ^ s3) | 1; forced odd, so the K indices are distinct for K ≤ M.
  - idx_i = (h1 + i*h2) mod M. Implemented as an accumulator: idx starts at h1, and each probe cycle does idx += h2, truncated to LOG_M bits (wraps).
- FSM states and transitions:
  - IDLE:
    - in_ready = !clr.
    - clr=1: clear array and counter in one cycle, stay in IDLE, accept no key even if in_valid=1.
    - in_valid & in_ready: latch key, op, h2 and idx=h1; clear the probe vector; set probe counter to 0; go to PROBE.
  - PROBE (K cycles, i = 0..K-1):
    - probe[i] <= array[idx].
    - If op = insert: array[idx] <= 1.
    - idx <= idx + h2.
    - After i = K-1, go to DONE. If op = insert, also increment insert_count (saturating).
  - DONE:
    - out_valid = 1; out_probe and out_op are held stable.
    - On out_ready, go to IDLE.
- Probe bits show the array value before the transaction's own write. An insert therefore reports whether the key was already (possibly) present.
- clr and in_valid are ignored outside IDLE. in_ready = 0 in PROBE and DONE.

## Timing
- Reset (async, rst_n=0): state IDLE, array all 0, in_ready=1 (when clr=0), out_valid=0, out_probe=0, out_op=0, insert_count=0.
- Accept handshake on edge E0. Probe i is sampled on edge E(i+1). out_valid is high from the cycle after edge EK.
- Latency from accept to out_valid: K+1 cycles. Minimum throughput: one key per K+2 cycles, with out_ready tied high.
- Output handshake completes on the edge where out_valid & out_ready are both high. in_ready rises in the next cycle; there is no same-cycle bypass.
- Backpressure: DONE holds indefinitely. Outputs must not change while out_valid=1 and out_ready=0.
- Reset mid-PROBE or mid-DONE: the transaction is abandoned, no result is emitted, and the array and counter are cleared.
- clr takes effect on the edge it is sampled in IDLE. in_ready is 0 combinationally in that cycle.

## Test plan
- Empty query: after reset, query key 0x00000000 (indices 0,1,2,3) -> out_probe=4'b0000, out_op=0, out_valid in cycle K+1 = 5 after accept.
- Insert then re-query:
  - Insert 0x00000000 -> out_probe=4'b0000, insert_count=1.
  - Query 0x00000000 -> out_probe=4'b1111.
  - Insert 0x00000000 again -> out_probe=4'b1111, insert_count=2.
- Disjoint, overlap and wrap, with only key 0 inserted:
  - Query 0x01020304 (h1=0x07, h2=0x03, indices 7,10,13,16) -> 4'b0000.
  - Query 0x00000002 (indices 2,3,4,5) -> 4'b0011.
  - Query 0x000000FF (indices 255,0,1,2) -> 4'b1110.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, while driving in_valid=1 with another key.
  - out_valid stays 1, out_probe stays stable, in_ready stays 0.
  - The second key is accepted only in the cycle after out_ready=1.
- Clear priority: after inserts, assert clr and in_valid together in IDLE.
  - The key is not accepted and insert_count becomes 0.
  - A following query of 0x00000000 -> 4'b0000.
  - clr pulsed during PROBE has no effect.
- Async reset mid-PROBE: drop rst_n on probe cycle 2 of an insert.
  - All outputs go to their reset values immediately, and no out_valid is produced.
  - A subsequent query of the same key -> 4'b0000.
